fsqrt_seq_unit: RTL and testbench

Sequential IEEE-754 single-precision square-root unit for the F-extension execute path. It accepts one operand and a rounding mode through a start/ready handshake and classifies special operands. Finite positive operands go through a 25-step restoring digit recurrence on the mantissa, built on the block's enable/clear pipeline registers. It returns a rounded result plus RISC-V fflags with a one-cycle valid pulse.

---
 rtl/fsqrt_seq_unit_if.sv | 22 ++
 rtl/fsqrt_seq_unit.sv | 186 ++++++++++++++++++
 tb/tb_fsqrt_seq_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fsqrt_seq_unit_if.sv
// Request/response bundle of the FP32 square-root unit.
// master: start/flush/a/rm out; slave: ready/valid/result/fflags out.
interface fsqrt_seq_unit_if;
  logic        start;
  logic        flush;
  logic [31:0] a;
  logic [2:0]  rm;
  logic        ready;
  logic        valid;
  logic [31:0] result;
  logic [4:0]  fflags;

  modport master (
    output start, flush, a, rm,
    input  ready, valid, result, fflags
  );

  modport slave (
    input  start, flush, a, rm,
    output ready, valid, result, fflags
  );
endinterface

// File: rtl/fsqrt_seq_unit.sv
// Sequential FP32 square root, 25-step restoring recurrence.
// Ports: clk, rst_n (async low), io (slave: start/flush/a/rm -> ready/valid/result/fflags).
module fsqrt_seq_unit (
  input  logic              clk,
  input  logic              rst_n,
  fsqrt_seq_unit_if.slave   io
);

  typedef enum logic [2:0] {
    IDLE, PREP, ITER, ROUND, DONE
  } state_t;

  state_t      state;
  logic [31:0] a_q;
  logic [2:0]  rm_q;
  logic [4:0]  cnt;
  logic [49:0] x;
  logic [24:0] q;
  logic [27:0] r;
  logic [7:0]  eh;
  logic [31:0] res_s;
  logic [4:0]  flg_s;

  // operand classification
  logic        sgn;
  logic [7:0]  ex;
  logic [22:0] fr;
  logic        is_nan;
  logic        is_inf;
  logic        is_zero;
  logic        is_sub;

  assign sgn     = a_q[31];
  assign ex      = a_q[30:23];
  assign fr      = a_q[22:0];
  assign is_nan  = (ex == 8'hFF) && (fr != 23'd0);
  assign is_inf  = (ex == 8'hFF) && (fr == 23'd0);
  assign is_zero = (ex == 8'h00) && (fr == 23'd0);
  assign is_sub  = (ex == 8'h00) && (fr != 23'd0);

  // normalization and radicand setup
  logic [23:0] m0;
  logic [4:0]  lz;
  logic [23:0] m_n;
  logic [8:0]  e_n;
  logic [49:0] x_n;

  assign m0 = {1'b0, fr};

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 24; i++)
      if (m0[i]) lz = 5'(23 - i);
  end

  assign m_n = is_sub ? (m0 << lz) : {1'b1, fr};
  assign e_n = is_sub ? (9'(-126) - {4'd0, lz})
                      : ({1'b0, ex} - 9'd127);
  // odd exponent: fold one factor of two into the radicand
  assign x_n = e_n[0] ? {m_n, 26'd0}
                      : {1'b0, m_n, 25'd0};

  // one restoring step
  logic [27:0] r_sh;
  logic [27:0] trial;
  logic        ge;

  assign r_sh  = (r << 2) | {26'd0, x[49:48]};
  assign trial = {1'b0, q, 2'b01};
  assign ge    = r_sh >= trial;

  // rounding
  logic        guard;
  logic        sticky;
  logic        rm_up;
  logic        rm_dn;
  logic        inc;
  logic        carry;
  logic [22:0] frac;
  logic [7:0]  exp8;

  assign guard  = q[0];
  assign sticky = r != 28'd0;
  assign rm_up  = rm_q == 3'b011;
  assign rm_dn  = (rm_q == 3'b001) || (rm_q == 3'b010);

  always_comb begin
    inc = 1'b0;
    unique case (1'b1)
      rm_up:   inc = guard | sticky;
      rm_dn:   inc = 1'b0;
      default: inc = guard;
    endcase
  end

  // q[24] is always set, so only the fraction can overflow
  assign carry = inc & (&q[23:1]);
  assign frac  = q[23:1] + {22'd0, inc};
  assign exp8  = eh + 8'd127 + {7'd0, carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= 32'd0;
      rm_q      <= 3'd0;
      cnt       <= 5'd0;
      x         <= 50'd0;
      q         <= 25'd0;
      r         <= 28'd0;
      eh        <= 8'd0;
      res_s     <= 32'd0;
      flg_s     <= 5'd0;
      io.ready  <= 1'b1;
      io.valid  <= 1'b0;
      io.result <= 32'd0;
      io.fflags <= 5'd0;
    end else begin
      io.valid <= 1'b0;
      if (io.flush) begin
        state    <= IDLE;
        io.ready <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (io.start) begin
              a_q      <= io.a;
              rm_q     <= io.rm;
              state    <= PREP;
              io.ready <= 1'b0;
            end
          end
          PREP: begin
            if (is_nan) begin
              res_s <= 32'h7FC00000;
              flg_s <= {~fr[22], 4'd0};
              state <= DONE;
            end else if (is_zero) begin
              res_s <= a_q;
              flg_s <= 5'd0;
              state <= DONE;
            end else if (sgn) begin
              res_s <= 32'h7FC00000;
              flg_s <= 5'b10000;
              state <= DONE;
            end else if (is_inf) begin
              res_s <= 32'h7F800000;
              flg_s <= 5'd0;
              state <= DONE;
            end else begin
              x     <= x_n;
              eh    <= e_n[8:1];
              q     <= 25'd0;
              r     <= 28'd0;
              cnt   <= 5'd24;
              state <= ITER;
            end
          end
          ITER: begin
            x <= x << 2;
            q <= {q[23:0], ge};
            r <= ge ? (r_sh - trial) : r_sh;
            if (cnt == 5'd0) state <= ROUND;
            else             cnt   <= cnt - 5'd1;
          end
          ROUND: begin
            res_s <= {1'b0, exp8, frac};
            flg_s <= {4'd0, guard | sticky};
            state <= DONE;
          end
          DONE: begin
            io.valid  <= 1'b1;
            io.result <= res_s;
            io.fflags <= flg_s;
            io.ready  <= 1'b1;
            state     <= IDLE;
          end
          default: begin
            state    <= IDLE;
            io.ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsqrt_seq_unit.sv
// Directed bench for fsqrt_seq_unit.
// Drives/samples on negedge; all expectations are hand-computed constants.
module tb_fsqrt_seq_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  fsqrt_seq_unit_if bus();

  fsqrt_seq_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] av,
                        input logic [2:0]  rmv,
                        input logic [31:0] er,
                        input logic [4:0]  ef,
                        input int          el,
                        input int          poke);
    int lat;
    lat = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.rm    = rmv;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, {31'd0, bus.ready}, 32'd0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.valid) begin
        lat = k;
        break;
      end
      if (k == poke) begin
        bus.start = 1'b1;
        bus.a     = 32'h40000000;
        bus.rm    = 3'b011;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(el));
    check({tag, "_res"}, bus.result, er);
    check({tag, "_flg"}, {27'd0, bus.fflags}, {27'd0, ef});
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, bus.valid}, 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.valid) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs [16] = '{
    '{32'h40800000, 3'b000, 32'h40000000, 5'h00, 28},
    '{32'h40000000, 3'b000, 32'h3FB504F3, 5'h01, 28},
    '{32'h40000000, 3'b011, 32'h3FB504F4, 5'h01, 28},
    '{32'h40000000, 3'b001, 32'h3FB504F3, 5'h01, 28},
    '{32'h40000000, 3'b010, 32'h3FB504F3, 5'h01, 28},
    '{32'h40000000, 3'b100, 32'h3FB504F3, 5'h01, 28},
    '{32'h40000000, 3'b111, 32'h3FB504F3, 5'h01, 28},
    '{32'h407FFFFF, 3'b011, 32'h40000000, 5'h01, 28},
    '{32'h407FFFFF, 3'b000, 32'h3FFFFFFF, 5'h01, 28},
    '{32'hC0800000, 3'b000, 32'h7FC00000, 5'h10, 2},
    '{32'h7F800001, 3'b000, 32'h7FC00000, 5'h10, 2},
    '{32'h7FC00000, 3'b000, 32'h7FC00000, 5'h00, 2},
    '{32'h80000000, 3'b000, 32'h80000000, 5'h00, 2},
    '{32'h7F800000, 3'b000, 32'h7F800000, 5'h00, 2},
    '{32'h00000001, 3'b000, 32'h1A3504F3, 5'h01, 28},
    '{32'h3F800000, 3'b000, 32'h3F800000, 5'h00, 28}
  };

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.a     = 32'd0;
    bus.rm    = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'd0, bus.ready}, 32'd1);
    check("rst_valid",  {31'd0, bus.valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_fflags", {27'd0, bus.fflags}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("v%0d", i), vecs[i].a, vecs[i].rm,
             vecs[i].res, vecs[i].flg, vecs[i].lat, 0);

    // start during ITER must be dropped, not queued
    run_op("poke", 32'h40800000, 3'b000,
           32'h40000000, 5'h00, 28, 5);
    expect_quiet("poke_noq", 35);

    // flush in cycle 10
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h40000000;
    bus.rm    = 3'b011;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("fl_ready", {31'd0, bus.ready}, 32'd1);
    check("fl_valid", {31'd0, bus.valid}, 32'd0);
    expect_quiet("fl_quiet", 35);
    check("fl_res", bus.result, 32'h40000000);
    check("fl_flg", {27'd0, bus.fflags}, 32'd0);

    // start with flush in the same cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.a     = 32'h40000000;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("sf_ready", {31'd0, bus.ready}, 32'd1);
    expect_quiet("sf_quiet", 35);

    run_op("after", 32'h40800000, 3'b000,
           32'h40000000, 5'h00, 28, 0);

    // reset mid-ITER
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h40000000;
    bus.rm    = 3'b000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_ready",  {31'd0, bus.ready}, 32'd1);
    check("mr_valid",  {31'd0, bus.valid}, 32'd0);
    check("mr_result", bus.result, 32'd0);
    check("mr_fflags", {27'd0, bus.fflags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("mr_quiet", 35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
